// File: rtl/alu_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract unit.
package alu_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } serial_state_t;

   localparam int DEFAULT_WIDTH = 64;

   // Bit counter must hold WIDTH-1; never narrower than one bit.
   function automatic int counterWidth(input int width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder with optional B inversion (control = 1 selects A + ~B + carryIn).
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic carryIn,
   input  logic control,
   output logic sum,
   output logic carryOut
);

   logic bEff_s;

   assign bEff_s   = control ? ~b : b;
   assign sum      = a ^ bEff_s ^ carryIn;
   assign carryOut = (a & bEff_s) | (a & carryIn) | (bEff_s & carryIn);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract: one fullAdder stepped LSB-first, one bit per clock,
// producing the result and N/Z/C/V flags with a start/busy/done handshake.
module serial_add_sub
   import alu_serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);

   localparam int            CW         = counterWidth(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

   serial_state_t    state_r;
   serial_state_t    stateNext_s;
   logic [WIDTH-1:0] aSh_r;
   logic [WIDTH-1:0] bSh_r;
   logic [WIDTH-2:0] resSh_r;
   logic [WIDTH-1:0] resShNext_s;
   logic [CW-1:0]    count_r;
   logic             subLat_r;
   logic             carry_r;
   logic             zeroAcc_r;
   logic             lastBit_s;
   logic             sumBit_s;
   logic             carryOutBit_s;

   fullAdder u_fullAdder (
      .a        (aSh_r[0]),
      .b        (bSh_r[0]),
      .carryIn  (carry_r),
      .control  (subLat_r),
      .sum      (sumBit_s),
      .carryOut (carryOutBit_s)
   );

   // Next-state decode and the result word as it will look after this bit is shifted in.
   always_comb begin
      stateNext_s = state_r;
      lastBit_s   = (count_r == LAST_COUNT);
      resShNext_s = {sumBit_s, resSh_r};
      case (state_r)
         IDLE: begin
            if (start) begin
               stateNext_s = RUN;
            end else begin
               stateNext_s = IDLE;
            end
         end
         RUN: begin
            if (lastBit_s) begin
               stateNext_s = DONE;
            end else begin
               stateNext_s = RUN;
            end
         end
         DONE:    stateNext_s = IDLE;
         default: stateNext_s = IDLE;
      endcase
   end

   // State register with registered handshake outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= stateNext_s;
         busy    <= (stateNext_s != IDLE);
         done    <= (stateNext_s == DONE);
      end
   end

   // Operand shifters, carry/zero tracking and result/flag capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aSh_r     <= '0;
         bSh_r     <= '0;
         resSh_r   <= '0;
         count_r   <= '0;
         subLat_r  <= 1'b0;
         carry_r   <= 1'b0;
         zeroAcc_r <= 1'b0;
         result    <= '0;
         negative  <= 1'b0;
         zero      <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  aSh_r     <= a;
                  bSh_r     <= b;
                  subLat_r  <= sub;
                  carry_r   <= sub;  // +1 of the two's-complement negate
                  count_r   <= '0;
                  zeroAcc_r <= 1'b0;
               end
            end
            RUN: begin
               aSh_r     <= {1'b0, aSh_r[WIDTH-1:1]};
               bSh_r     <= {1'b0, bSh_r[WIDTH-1:1]};
               resSh_r   <= resShNext_s[WIDTH-1:1];
               carry_r   <= carryOutBit_s;
               zeroAcc_r <= zeroAcc_r | sumBit_s;
               if (lastBit_s) begin
                  // carry_r here is the carry into the MSB
                  result    <= resShNext_s;
                  negative  <= sumBit_s;
                  zero      <= ~(zeroAcc_r | sumBit_s);
                  carry_out <= carryOutBit_s;
                  overflow  <= carry_r ^ carryOutBit_s;
               end else begin
                  count_r <= count_r + ONE_COUNT;
               end
            end
            DONE: begin
               count_r <= '0;
            end
            default: begin
               count_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub at WIDTH = 64.
module tb_serial_add_sub;

   localparam int W = 64;

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         sub   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy, done, negative, zero, carry_out, overflow;
   logic [W-1:0] result;

   int passCnt  = 0;
   int totalCnt = 0;

   always #500 clk = ~clk;

   serial_add_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .negative  (negative),
      .zero      (zero),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   // Launch one operation, scramble the inputs after acceptance, and count cycles to done.
   task automatic runOp(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opSub, output int lat);
      repeat (2) @(negedge clk);
      a = opA; b = opB; sub = opSub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~opA; b = ~opB; sub = ~opSub;
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      #100;
      totalCnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passCnt++;
      totalCnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passCnt++;
      totalCnt++; if (result !== 64'd0) $display("FAIL rst_result: got %h want 0", result); else passCnt++;
      totalCnt++; if ({negative, zero, carry_out, overflow} !== 4'b0000)
         $display("FAIL rst_flags: got %b want 0000", {negative, zero, carry_out, overflow}); else passCnt++;
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_add;
      int lat;
      runOp(64'd5, 64'd3, 1'b0, lat);
      totalCnt++; if (lat !== 64) $display("FAIL add_latency: got %0d want 64", lat); else passCnt++;
      totalCnt++; if (result !== 64'd8) $display("FAIL add_result: got %h want %h", result, 64'd8); else passCnt++;
      totalCnt++; if ({negative, zero, carry_out, overflow} !== 4'b0000)
         $display("FAIL add_flags: got %b want 0000", {negative, zero, carry_out, overflow}); else passCnt++;
      totalCnt++; if (busy !== 1'b1) $display("FAIL add_busy_done: got %b want 1", busy); else passCnt++;
      @(posedge clk); #1;
      totalCnt++; if (done !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", done); else passCnt++;
      totalCnt++; if (busy !== 1'b0) $display("FAIL add_busy_idle: got %b want 0", busy); else passCnt++;
      totalCnt++; if (result !== 64'd8) $display("FAIL add_hold: got %h want %h", result, 64'd8); else passCnt++;
   endtask

   task automatic test_sub;
      int lat;
      runOp(64'd3, 64'd5, 1'b1, lat);
      totalCnt++; if (lat !== 64) $display("FAIL sub_latency: got %0d want 64", lat); else passCnt++;
      totalCnt++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE)
         $display("FAIL sub_result: got %h want %h", result, 64'hFFFF_FFFF_FFFF_FFFE); else passCnt++;
      totalCnt++; if ({negative, zero, carry_out, overflow} !== 4'b1000)
         $display("FAIL sub_flags: got %b want 1000", {negative, zero, carry_out, overflow}); else passCnt++;
   endtask

   task automatic test_overflow;
      int lat;
      runOp(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
      totalCnt++; if (result !== 64'h8000_0000_0000_0000)
         $display("FAIL ovf_add_result: got %h want %h", result, 64'h8000_0000_0000_0000); else passCnt++;
      totalCnt++; if ({negative, zero, carry_out, overflow} !== 4'b1001)
         $display("FAIL ovf_add_flags: got %b want 1001", {negative, zero, carry_out, overflow}); else passCnt++;
      runOp(64'd5, 64'd5, 1'b1, lat);
      totalCnt++; if (result !== 64'd0) $display("FAIL eq_sub_result: got %h want 0", result); else passCnt++;
      totalCnt++; if ({negative, zero, carry_out, overflow} !== 4'b0110)
         $display("FAIL eq_sub_flags: got %b want 0110", {negative, zero, carry_out, overflow}); else passCnt++;
   endtask

   task automatic test_carry;
      int lat;
      runOp(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
      totalCnt++; if (result !== 64'd0) $display("FAIL wrap_result: got %h want 0", result); else passCnt++;
      totalCnt++; if ({negative, zero, carry_out, overflow} !== 4'b0110)
         $display("FAIL wrap_flags: got %b want 0110", {negative, zero, carry_out, overflow}); else passCnt++;
      runOp(64'h8000_0000_0000_0000, 64'd1, 1'b1, lat);
      totalCnt++; if (result !== 64'h7FFF_FFFF_FFFF_FFFF)
         $display("FAIL ovf_sub_result: got %h want %h", result, 64'h7FFF_FFFF_FFFF_FFFF); else passCnt++;
      totalCnt++; if ({negative, zero, carry_out, overflow} !== 4'b0011)
         $display("FAIL ovf_sub_flags: got %b want 0011", {negative, zero, carry_out, overflow}); else passCnt++;
   endtask

   task automatic test_ignore_start;
      int doneCount = 0;
      int doneCycle = -1;
      logic busyAtDone = 1'b0;
      logic busyAfter  = 1'b1;
      int lat;
      repeat (2) @(negedge clk);
      a = 64'd2; b = 64'd2; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 1; c <= W + 40; c++) begin
         @(posedge clk); #1;
         if (c == 9) begin
            a = 64'd9; b = 64'd9; start = 1'b1;
         end else if (c == 10) begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            doneCount++;
            doneCycle  = c;
            busyAtDone = busy;
         end
         if (doneCycle > 0 && c == doneCycle + 1) busyAfter = busy;
      end
      totalCnt++; if (doneCount !== 1) $display("FAIL ign_done_count: got %0d want 1", doneCount); else passCnt++;
      totalCnt++; if (doneCycle !== 64) $display("FAIL ign_done_cycle: got %0d want 64", doneCycle); else passCnt++;
      totalCnt++; if (result !== 64'd4) $display("FAIL ign_result: got %h want 4", result); else passCnt++;
      totalCnt++; if (busyAtDone !== 1'b1) $display("FAIL ign_busy_done: got %b want 1", busyAtDone); else passCnt++;
      totalCnt++; if (busyAfter !== 1'b0) $display("FAIL ign_busy_after: got %b want 0", busyAfter); else passCnt++;
      runOp(64'd1, 64'd2, 1'b0, lat);
      totalCnt++; if (lat !== 64) $display("FAIL ign_fresh_latency: got %0d want 64", lat); else passCnt++;
      totalCnt++; if (result !== 64'd3) $display("FAIL ign_fresh_result: got %h want 3", result); else passCnt++;
   endtask

   task automatic test_reset_abort;
      int doneCount = 0;
      int lat;
      repeat (2) @(negedge clk);
      a = 64'hFFFF_0000_1234_5678; b = 64'd1; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      #1;
      totalCnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passCnt++;
      totalCnt++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else passCnt++;
      totalCnt++; if (result !== 64'd0) $display("FAIL abort_result: got %h want 0", result); else passCnt++;
      totalCnt++; if ({negative, zero, carry_out, overflow} !== 4'b0000)
         $display("FAIL abort_flags: got %b want 0000", {negative, zero, carry_out, overflow}); else passCnt++;
      @(negedge clk); reset = 1'b1;
      for (int c = 0; c < W + 20; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) doneCount++;
      end
      totalCnt++; if (doneCount !== 0) $display("FAIL abort_no_done: got %0d want 0", doneCount); else passCnt++;
      runOp(64'd1, 64'd1, 1'b0, lat);
      totalCnt++; if (lat !== 64) $display("FAIL abort_new_latency: got %0d want 64", lat); else passCnt++;
      totalCnt++; if (result !== 64'd2) $display("FAIL abort_new_result: got %h want 2", result); else passCnt++;
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_overflow;
      test_carry;
      test_ignore_start;
      test_reset_abort;
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
